// File: rtl/rx_dc_cal_ctrl.sv
// RX DC-offset calibration sequencer on the settings bus: clears the frontend offsets,
// averages 2^LOG_N I/Q samples, and writes back the negated means. Host writes always win.
module rx_dc_cal_ctrl #(
  parameter int BASE      = 0,
  parameter int CTRL_ADDR = 8,
  parameter int LOG_N     = 10,
  parameter int SETTLE    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic        fe_set_stb,
  output logic [7:0]  fe_set_addr,
  output logic [31:0] fe_set_data,
  input  logic [23:0] i_in,
  input  logic [23:0] q_in,
  input  logic        run,
  output logic        busy,
  output logic        done,
  output logic [31:0] debug
);

  localparam int             AW          = 24 + LOG_N;
  localparam logic [7:0]     I_ADDR      = 8'(BASE + 3);
  localparam logic [7:0]     Q_ADDR      = 8'(BASE + 4);
  localparam logic [7:0]     CTRL        = 8'(CTRL_ADDR);
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [LOG_N:0] N_SAMP      = {1'b1, {LOG_N{1'b0}}};
  localparam logic [LOG_N:0] CNT_ONE     = {{LOG_N{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR_I  = 3'd1,
    S_CLR_Q  = 3'd2,
    S_SETTLE = 3'd3,
    S_ACCUM  = 3'd4,
    S_CALC   = 3'd5,
    S_WR_I   = 3'd6,
    S_WR_Q   = 3'd7
  } state_e;

  state_e             state_q;
  logic [7:0]         settle_cnt_q;
  logic [LOG_N:0]     sample_cnt_q;
  logic signed [AW-1:0] acc_i_q, acc_q_q;
  logic signed [23:0] corr_i_q, corr_q_q;
  logic               fe_set_stb_q;
  logic [7:0]         fe_set_addr_q;
  logic [31:0]        fe_set_data_q;
  logic               done_q;

  logic               ctrl_wr, abort, start;
  logic signed [AW-1:0] i_ext, q_ext, acc_i_d, acc_q_d, shr_i, shr_q;
  logic [LOG_N:0]     sample_cnt_d;
  logic signed [23:0] mean_i, mean_q;

  // Abort wins over start when a single control write carries both bits.
  assign ctrl_wr = set_stb && (set_addr == CTRL);
  assign abort   = ctrl_wr && set_data[1];
  assign start   = ctrl_wr && set_data[0] && !set_data[1];

  assign i_ext        = {{LOG_N{i_in[23]}}, i_in};
  assign q_ext        = {{LOG_N{q_in[23]}}, q_in};
  assign acc_i_d      = acc_i_q + i_ext;
  assign acc_q_d      = acc_q_q + q_ext;
  assign sample_cnt_d = sample_cnt_q + CNT_ONE;

  // The mean of 2^LOG_N 24-bit samples always fits back into 24 bits.
  assign shr_i  = acc_i_q >>> LOG_N;
  assign shr_q  = acc_q_q >>> LOG_N;
  assign mean_i = shr_i[23:0];
  assign mean_q = shr_q[23:0];

  function automatic logic signed [23:0] neg_sat(input logic signed [23:0] m);
    return (m == 24'sh800000) ? 24'sh7FFFFF : -m;
  endfunction

  // NOTE: every register below is written with <= so all updates see pre-edge values;
  // the async reset clears the datapath registers too, so a restart never sees stale sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      settle_cnt_q  <= '0;
      sample_cnt_q  <= '0;
      acc_i_q       <= '0;
      acc_q_q       <= '0;
      corr_i_q      <= '0;
      corr_q_q      <= '0;
      fe_set_stb_q  <= 1'b0;
      fe_set_addr_q <= '0;
      fe_set_data_q <= '0;
      done_q        <= 1'b0;
    end else begin
      fe_set_stb_q <= set_stb;
      done_q       <= 1'b0;
      if (set_stb) begin
        fe_set_addr_q <= set_addr;
        fe_set_data_q <= set_data;
      end

      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q      <= S_CLR_I;
              acc_i_q      <= '0;
              acc_q_q      <= '0;
              sample_cnt_q <= '0;
            end
          end
          S_CLR_I: begin
            if (!set_stb) begin
              fe_set_stb_q  <= 1'b1;
              fe_set_addr_q <= I_ADDR;
              fe_set_data_q <= '0;
              state_q       <= S_CLR_Q;
            end
          end
          S_CLR_Q: begin
            if (!set_stb) begin
              fe_set_stb_q  <= 1'b1;
              fe_set_addr_q <= Q_ADDR;
              fe_set_data_q <= '0;
              settle_cnt_q  <= '0;
              state_q       <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) state_q <= S_ACCUM;
            else                             settle_cnt_q <= settle_cnt_q + 8'd1;
          end
          S_ACCUM: begin
            if (run) begin
              acc_i_q      <= acc_i_d;
              acc_q_q      <= acc_q_d;
              sample_cnt_q <= sample_cnt_d;
              if (sample_cnt_d == N_SAMP) state_q <= S_CALC;
            end
          end
          S_CALC: begin
            corr_i_q <= neg_sat(mean_i);
            corr_q_q <= neg_sat(mean_q);
            state_q  <= S_WR_I;
          end
          S_WR_I: begin
            if (!set_stb) begin
              fe_set_stb_q  <= 1'b1;
              fe_set_addr_q <= I_ADDR;
              fe_set_data_q <= {{8{corr_i_q[23]}}, corr_i_q};
              state_q       <= S_WR_Q;
            end
          end
          S_WR_Q: begin
            if (!set_stb) begin
              fe_set_stb_q  <= 1'b1;
              fe_set_addr_q <= Q_ADDR;
              fe_set_data_q <= {{8{corr_q_q[23]}}, corr_q_q};
              done_q        <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fe_set_stb  = fe_set_stb_q;
  assign fe_set_addr = fe_set_addr_q;
  assign fe_set_data = fe_set_data_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign debug       = {1'b0, state_q, {(27 - LOG_N){1'b0}}, sample_cnt_q};

endmodule

// File: tb/tb_rx_dc_cal_ctrl.sv
// Scoreboard bench for rx_dc_cal_ctrl: expected frontend writes are queued as stimulus is
// driven and compared in order as the DUT emits them.
module tb_rx_dc_cal_ctrl;
  localparam int BASE = 0, CTRL_ADDR = 8, LOG_N = 4, SETTLE = 4;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_ACCUM = 4'd4, ST_WR_I = 4'd6;

  logic        clk, rst_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        fe_set_stb;
  logic [7:0]  fe_set_addr;
  logic [31:0] fe_set_data;
  logic [23:0] i_in, q_in;
  logic        run;
  logic        busy, done;
  logic [31:0] debug;

  int total = 0, bad = 0;
  int done_cnt = 0, exp_done = 0;
  logic [39:0] exp_q[$];
  int cyc = 0;
  int i_kind = 0, run_kind = 0;
  logic [23:0] i_val = 24'h000100, q_val = 24'hFFFF00;

  rx_dc_cal_ctrl #(.BASE(BASE), .CTRL_ADDR(CTRL_ADDR), .LOG_N(LOG_N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .fe_set_stb(fe_set_stb), .fe_set_addr(fe_set_addr), .fe_set_data(fe_set_data),
    .i_in(i_in), .q_in(q_in), .run(run),
    .busy(busy), .done(done), .debug(debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference correction: floor(sum / 2^LOG_N), negated, with the -2^23 case saturated.
  function automatic logic [31:0] corr(input longint sum);
    longint m;
    m = sum >>> LOG_N;
    if (m == -(longint'(1) << 23)) m = (longint'(1) << 23) - 1;
    else                           m = -m;
    return 32'(m);
  endfunction

  // Sample source; run=0 cycles carry junk so pausing is actually exercised.
  initial begin
    run  = 1'b1;
    i_in = '0;
    q_in = '0;
    forever begin
      @(negedge clk);
      cyc++;
      run  = (run_kind == 0) ? 1'b1 : (cyc % 3 == 0);
      i_in = !run ? 24'h123456 : ((i_kind == 1 && cyc[0]) ? 24'h000000 : i_val);
      q_in = !run ? 24'hABCDEF : q_val;
    end
  end

  // Output monitor: pops one expected write per observed strobe.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rst_n && fe_set_stb) begin
        if (exp_q.size() == 0) begin
          check("extra_wr", {24'h0, fe_set_addr, fe_set_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("fe_wr", {24'h0, fe_set_addr, fe_set_data}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  task automatic start_cal();
    exp_q.push_back({8'(CTRL_ADDR), 32'h1});
    exp_q.push_back({8'(BASE + 3), 32'h0});
    exp_q.push_back({8'(BASE + 4), 32'h0});
    set_stb  = 1'b1;
    set_addr = 8'(CTRL_ADDR);
    set_data = 32'h1;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int min_cnt);
    bit ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (debug[31:28] == st && int'(debug[27:0]) >= min_cnt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, ok, 1);
  endtask

  task automatic run_cal(input logic [31:0] ci, input logic [31:0] cq, input bit burst);
    bit ok = 1'b0;
    start_cal();
    if (burst) begin
      wait_state("reach_wr_i", ST_WR_I, 0);
      for (int k = 0; k < 5; k++) begin
        set_stb  = 1'b1;
        set_addr = 8'h40 + 8'(k);
        set_data = $urandom;
        exp_q.push_back({set_addr, set_data});
        @(negedge clk);
      end
      set_stb = 1'b0;
    end
    exp_q.push_back({8'(BASE + 3), ci});
    exp_q.push_back({8'(BASE + 4), cq});
    for (int n = 0; n < 500; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", ok, 1);
    exp_done++;
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    #1;
    check("rst_fe_stb", fe_set_stb, 0);
    check("rst_fe_addr", fe_set_addr, 0);
    check("rst_fe_data", fe_set_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_debug", debug, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic calibration, then the same with host traffic during WR_I.
    run_cal(corr(16 * 256), corr(16 * -256), 1'b0);
    run_cal(corr(16 * 256), corr(16 * -256), 1'b1);

    // Rounding toward -inf and negative inputs.
    i_kind = 1; i_val = 24'h000003; q_val = 24'h000005;
    run_cal(corr(24), corr(80), 1'b0);
    i_kind = 0; i_val = 24'hFFFFFD;
    run_cal(corr(-48), corr(80), 1'b0);

    // Full-scale extremes, including the saturating case.
    i_val = 24'h800000; q_val = 24'h7FFFFF;
    run_cal(corr(-16 * 64'sd8388608), corr(16 * 64'sd8388607), 1'b0);

    // Paused accumulation must match the continuous result.
    run_kind = 1; i_val = 24'h000100; q_val = 24'hFFFF00;
    run_cal(corr(16 * 256), corr(16 * -256), 1'b0);
    run_kind = 0;

    // Start together with abort is ignored.
    host_wr(8'(CTRL_ADDR), 32'h3);
    repeat (10) @(negedge clk);
    check("start_abort_busy", busy, 0);
    check("start_abort_state", debug[31:28], ST_IDLE);

    // Abort mid-accumulation: no corrections and no done.
    start_cal();
    wait_state("reach_accum_abort", ST_ACCUM, 3);
    host_wr(8'(CTRL_ADDR), 32'h2);
    repeat (40) @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_no_done", done_cnt, exp_done);
    check("abort_queue", exp_q.size(), 0);

    // Reset during accumulation, then a clean run.
    i_val = 24'h000007; q_val = 24'hFFFFF7;
    start_cal();
    wait_state("reach_accum_rst", ST_ACCUM, 5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_fe_stb", fe_set_stb, 0);
    repeat (2) @(negedge clk);
    check("midrst_busy_hold", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", fe_set_stb, 0);
    run_cal(corr(16 * 7), corr(16 * -9), 1'b0);

    repeat (5) @(negedge clk);
    check("done_count", done_cnt, exp_done);
    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
